// File: rtl/store_pkg.sv
// Shared encodings for the narrowing store path: op codes, FSM states and the
// legality rule for a store request.
package store_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    OP_SB  = 2'd0,
    OP_SH  = 2'd1,
    OP_SW  = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRd    = 2'd1,
    StRwait = 2'd2,
    StWr    = 2'd3
  } state_e;

  // Reserved op, odd halfword address or unaligned word address.
  function automatic logic op_illegal(input op_e op, input logic [1:0] off);
    return (op == OP_RSV) || ((op == OP_SH) && off[0]) || ((op == OP_SW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian byte/halfword insert of a register value into an existing memory word.
module lane_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0] old_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  op_e               op_i,
  input  logic [1:0]        off_i,
  output logic [WORD_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    unique case (op_i)
      OP_SB: merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      OP_SH: begin
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      OP_SW:   merged_o = wdata_i;
      OP_RSV:  merged_o = old_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path into a word-only synchronous memory; SB/SH go through read-modify-write,
// SW writes directly. All outputs are registered.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WORD_W-1:0]   merged;

  op_e  req_op;
  logic req_bad;
  logic unused_addr;

  assign req_op      = op_e'(op_i);
  assign req_bad     = op_illegal(req_op, addr_i[1:0]);
  // Address bits above the memory's range wrap silently.
  assign unused_addr = ^addr_i[31:AW+2];

  lane_merge u_lane_merge (
    .old_i    (mem_rdata_i),
    .wdata_i  (wdata_q),
    .op_i     (op_q),
    .off_i    (off_q),
    .merged_o (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && !req_bad) state_d = (req_op == OP_SW) ? StWr : StRd;
      end
      StRd:    state_d = StRwait;
      StRwait: state_d = StWr;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if ((state_q == StIdle) && req_i) begin
      op_d       = req_op;
      off_d      = addr_i[1:0];
      wdata_d    = wdata_i;
      mem_addr_d = addr_i[AW+1:2];
      if (req_bad)              err_d       = 1'b1;
      else if (req_op == OP_SW) mem_wdata_d = wdata_i;
    end
    // mem_rdata_i carries the word addressed during StRd.
    if (state_q == StRwait) mem_wdata_d = merged;
    if (state_q == StWr)    done_d      = 1'b1;

    mem_we_d = (state_d == StWr);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q        <= OP_SB;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      op_q        <= op_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: a driver pushes expected memory writes/rejects,
// a monitor checks them against the DUT, and memory is compared to a model at the end.
module tb_store_rmw_unit;

  localparam int unsigned AW    = 8;
  localparam int unsigned Words = 1 << AW;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          req_i   = 1'b0;
  logic [1:0]    op_i    = 2'd0;
  logic [31:0]   addr_i  = '0;
  logic [31:0]   wdata_i = '0;
  logic          busy_o, done_o, err_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i;

  always #5 clk_i = ~clk_i;

  store_rmw_unit #(.AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Synchronous word memory with a preload port for the bench.
  logic [31:0]   mem [Words];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always @(posedge clk_i) begin
    if (pl_en)         mem[pl_addr]    <= pl_data;
    else if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= mem[mem_addr_o];
  end

  typedef struct {
    bit            is_err;
    logic [AW-1:0] waddr;
    logic [31:0]   word;
    int            t_resp;
  } exp_t;

  logic [31:0] ref_mem [Words];
  exp_t        exp_q[$];
  int          n_vec    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          done_due = -1;
  bit          mon_en   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] old, input int op,
                                             input int off, input logic [31:0] wd);
    int sh;
    if (op == 0) begin
      sh = 8 * off;
      return (old & ~(32'h0000_00FF << sh)) | ((wd & 32'h0000_00FF) << sh);
    end
    if (op == 1) begin
      sh = (off >= 2) ? 16 : 0;
      return (old & ~(32'h0000_FFFF << sh)) | ((wd & 32'h0000_FFFF) << sh);
    end
    return wd;
  endfunction

  function automatic bit model_bad(input int op, input int off);
    return (op == 3) || (op == 1 && (off % 2) == 1) || (op == 2 && off != 0);
  endfunction

  // Monitor
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en && rst_ni) begin
        if (done_o && err_o) check("done_err_excl", 32'(done_o & err_o), 32'd0);
        if (mem_we_o) begin
          if (exp_q.size() == 0 || exp_q[0].is_err) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_we: got addr %h data %h want no write", mem_addr_o,
                     mem_wdata_o);
          end else begin
            check("we_addr", 32'(mem_addr_o), 32'(exp_q[0].waddr));
            check("we_data", mem_wdata_o, exp_q[0].word);
            check("we_cycle", 32'(cyc), 32'(exp_q[0].t_resp));
            check("we_busy", 32'(busy_o), 32'd1);
            done_due = cyc + 1;
          end
        end
        if (done_o) begin
          check("done_cycle", 32'(cyc), 32'(done_due));
          check("done_busy", 32'(busy_o), 32'd0);
          if (exp_q.size() != 0 && !exp_q[0].is_err) void'(exp_q.pop_front());
          done_due = -1;
        end
        if (err_o) begin
          if (exp_q.size() == 0 || !exp_q[0].is_err) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_err: got err=1 want err=0 (cycle %0d)", cyc);
          end else begin
            check("err_cycle", 32'(cyc), 32'(exp_q[0].t_resp));
            check("err_busy", 32'(busy_o), 32'd0);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // All driver tasks start and end 2 time units after a rising edge.
  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic preload(input int wa, input logic [31:0] data);
    req_i   = 1'b0;
    pl_en   = 1'b1;
    pl_addr = AW'(wa);
    pl_data = data;
    ref_mem[wa] = data;
    @(posedge clk_i);
    #2;
    pl_en = 1'b0;
  endtask

  // Leaves req_i high on return so the caller can chain a back-to-back request.
  task automatic do_req(input int op, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   wa;
    int   off;
    bit   seen;
    wa  = int'(addr[AW+1:2]);
    off = int'(addr[1:0]);
    req_i   = 1'b1;
    op_i    = 2'(op);
    addr_i  = addr;
    wdata_i = wd;
    e.waddr = AW'(wa);
    e.word  = '0;
    if (model_bad(op, off)) begin
      e.is_err = 1'b1;
      e.t_resp = cyc + 1;
    end else begin
      e.is_err    = 1'b0;
      e.word      = model_word(ref_mem[wa], op, off, wd);
      ref_mem[wa] = e.word;
      e.t_resp    = cyc + ((op == 2) ? 1 : 3);
    end
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (done_o || err_o) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got no done/err want response for op %0d addr %h", op, addr);
      exp_q.delete();
      done_due = -1;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;

    repeat (2) @(posedge clk_i);
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);

    for (int i = 0; i < int'(Words); i++) preload(i, $urandom);
    rst_ni = 1'b1;
    mon_en = 1'b1;
    idle(2);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Word store
    preload(5, 32'hDEAD_BEEF);
    do_req(2, 32'h14, 32'h1234_5678);
    idle(2);

    // Byte into every lane
    for (int i = 0; i < 4; i++) begin
      preload(3, 32'hAABB_CCDD);
      do_req(0, 32'h0C + 32'(i), 32'h0000_00EE);
      idle(1);
    end

    // Halfwords, upper source bits ignored
    preload(2, 32'h1122_3344);
    do_req(1, 32'h0A, 32'hFFFF_8765);
    idle(1);
    preload(2, 32'h1122_3344);
    do_req(1, 32'h08, 32'hFFFF_8765);
    idle(1);

    // Rejects
    do_req(1, 32'h09, 32'h0000_1111);
    idle(1);
    do_req(2, 32'h0A, 32'h2222_2222);
    idle(1);
    do_req(3, 32'h00, 32'h3333_3333);
    idle(2);

    // Back-to-back with req held through done/err
    do_req(0, 32'h40, 32'h0000_0077);
    do_req(2, 32'h44, 32'hCAFE_F00D);
    do_req(1, 32'h102, 32'h0000_ABCD);
    do_req(3, 32'h48, 32'h0);
    do_req(0, 32'h43, 32'h0000_0099);
    idle(2);

    // Address wrap and top word
    do_req(2, 32'hFFFF_FFFC, 32'h0BAD_CAFE);
    do_req(0, 32'h0000_0401, 32'h0000_0055);
    idle(2);

    // Reset during RWAIT of a byte store
    preload(7, 32'h55AA_55AA);
    req_i   = 1'b1;
    op_i    = 2'd0;
    addr_i  = 32'h1C;
    wdata_i = 32'h0000_0011;
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    req_i  = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_we", 32'(mem_we_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_wdata", mem_wdata_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    idle(5);
    check("postrst_busy", 32'(busy_o), 32'd0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (op == 1) a[0] = 1'b0;
        if (op == 2) a[1:0] = 2'b00;
      end
      do_req(op, a, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < int'(Words); i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
